// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) byte master, MSB first, valid/ready transmit feed, strobed receive.
// Optional macro SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds mosi back into the receive shifter.

module spi_master #(
   parameter int HALF_PERIOD = 4,
   parameter int SS_SETUP    = 4,
   parameter int SS_HOLD     = 4,
   parameter int SS_IDLE     = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_byte,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_byte,
   output logic       rx_byte_available,
   output logic       busy,
   output logic       sclk,
   output logic       mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic       loopback,
`endif
   input  logic       miso,
   output logic       ss
);

   localparam int MAX_AB = (HALF_PERIOD > SS_SETUP) ? HALF_PERIOD : SS_SETUP;
   localparam int MAX_CD = (SS_HOLD > SS_IDLE) ? SS_HOLD : SS_IDLE;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] C_HALF  = CW'(HALF_PERIOD);
   localparam logic [CW-1:0] C_SETUP = CW'(SS_SETUP);
   localparam logic [CW-1:0] C_HOLD  = CW'(SS_HOLD);
   localparam logic [CW-1:0] C_IDLE  = CW'(SS_IDLE);

   typedef enum logic [2:0] {
      S_GAP, S_IDLE, S_SETUP, S_LOW, S_HIGH, S_NEXT, S_HOLD
   } state_t;

   state_t          r_state, w_state;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic [2:0]      r_bit, w_bit;
   logic [7:0]      r_tx, w_tx;
   logic            r_last, w_last;
   logic [7:0]      r_shift, w_shift;
   logic [7:0]      r_rx_byte, w_rx_byte;
   logic            r_rx_avail, w_rx_avail;
   logic            r_tx_ready, w_tx_ready;
   logic            r_busy, w_busy;
   logic            r_sclk, w_sclk;
   logic            r_mosi, w_mosi;
   logic            r_ss, w_ss;

   logic            w_accept;
   logic            w_cnt_done;
   logic [CW-1:0]   w_cnt_dec;
   logic            w_sample;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign w_sample = loopback ? r_mosi : miso;
`else
   assign w_sample = miso;
`endif

   assign w_accept   = tx_valid && r_tx_ready;
   assign w_cnt_done = (r_cnt == CW'(1));
   assign w_cnt_dec  = r_cnt - CW'(1);

   always_comb begin
      // NOTE: every next-state value gets a default before the case so no path can infer a latch.
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_bit      = r_bit;
      w_tx       = r_tx;
      w_last     = r_last;
      w_shift    = r_shift;
      w_rx_byte  = r_rx_byte;
      w_rx_avail = 1'b0;
      w_tx_ready = r_tx_ready;
      w_busy     = r_busy;
      w_sclk     = r_sclk;
      w_mosi     = r_mosi;
      w_ss       = r_ss;

      unique case (r_state)
         S_GAP: begin
            if (w_cnt_done) begin
               w_state    = S_IDLE;
               w_tx_ready = 1'b1;
               w_busy     = 1'b0;
            end else begin
               w_cnt = w_cnt_dec;
            end
         end
         S_IDLE: begin
            if (w_accept) begin
               w_tx       = tx_byte;
               w_last     = tx_last;
               w_mosi     = tx_byte[7];
               w_ss       = 1'b0;
               w_busy     = 1'b1;
               w_tx_ready = 1'b0;
               w_bit      = 3'd0;
               w_cnt      = C_SETUP;
               w_state    = S_SETUP;
            end
         end
         S_SETUP: begin
            if (w_cnt_done) begin
               w_cnt   = C_HALF;
               w_state = S_LOW;
            end else begin
               w_cnt = w_cnt_dec;
            end
         end
         S_LOW: begin
            if (w_cnt_done) begin
               w_sclk  = 1'b1;
               w_shift = {r_shift[6:0], w_sample};
               w_cnt   = C_HALF;
               w_state = S_HIGH;
            end else begin
               w_cnt = w_cnt_dec;
            end
         end
         S_HIGH: begin
            if (w_cnt_done) begin
               w_sclk = 1'b0;
               w_bit  = r_bit + 3'd1;
               if (r_bit == 3'd7) begin
                  w_rx_byte  = r_shift;
                  w_rx_avail = 1'b1;
                  if (r_last) begin
                     w_cnt   = C_HOLD;
                     w_state = S_HOLD;
                  end else begin
                     w_tx_ready = 1'b1;
                     w_state    = S_NEXT;
                  end
               end else begin
                  w_mosi  = r_tx[6];
                  w_tx    = {r_tx[6:0], 1'b0};
                  w_cnt   = C_HALF;
                  w_state = S_LOW;
               end
            end else begin
               w_cnt = w_cnt_dec;
            end
         end
         S_NEXT: begin
            // Continuation byte goes straight to the low phase; ss setup is not repeated.
            if (w_accept) begin
               w_tx       = tx_byte;
               w_last     = tx_last;
               w_mosi     = tx_byte[7];
               w_tx_ready = 1'b0;
               w_cnt      = C_HALF;
               w_state    = S_LOW;
            end
         end
         S_HOLD: begin
            if (w_cnt_done) begin
               w_ss    = 1'b1;
               w_cnt   = C_IDLE;
               w_state = S_GAP;
            end else begin
               w_cnt = w_cnt_dec;
            end
         end
         default: begin
            w_state    = S_GAP;
            w_cnt      = C_IDLE;
            w_ss       = 1'b1;
            w_sclk     = 1'b0;
            w_tx_ready = 1'b0;
            w_busy     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_GAP;
         r_cnt      <= C_IDLE;
         r_bit      <= 3'd0;
         r_tx       <= 8'h00;
         r_last     <= 1'b0;
         r_shift    <= 8'h00;
         r_rx_byte  <= 8'h00;
         r_rx_avail <= 1'b0;
         r_tx_ready <= 1'b0;
         r_busy     <= 1'b1;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_ss       <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values computed above.
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_bit      <= w_bit;
         r_tx       <= w_tx;
         r_last     <= w_last;
         r_shift    <= w_shift;
         r_rx_byte  <= w_rx_byte;
         r_rx_avail <= w_rx_avail;
         r_tx_ready <= w_tx_ready;
         r_busy     <= w_busy;
         r_sclk     <= w_sclk;
         r_mosi     <= w_mosi;
         r_ss       <= w_ss;
      end
   end

   assign tx_ready          = r_tx_ready;
   assign rx_byte           = r_rx_byte;
   assign rx_byte_available = r_rx_avail;
   assign busy              = r_busy;
   assign sclk              = r_sclk;
   assign mosi              = r_mosi;
   assign ss                = r_ss;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a per-cycle expected-waveform model (built from transaction timing rules)
// compared every cycle, plus literal checks of the headline timing numbers.

module tb_spi_master;

   localparam int HP = 4;
   localparam int SU = 4;
   localparam int SH = 4;
   localparam int SI = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       tx_valid, tx_last, loopback;
   logic [7:0] tx_byte;
   logic       tx_ready, rx_byte_available, busy, sclk, mosi, ss;
   logic [7:0] rx_byte;
   logic       miso;

   logic       f_tx_valid, f_tx_last;
   logic [7:0] f_tx_byte;
   logic       f_tx_ready, f_rx_avail, f_busy, f_sclk, f_mosi, f_ss;
   logic [7:0] f_rx_byte;

   logic [7:0] resp_mem [256];
   int         rise_cnt;

   assign miso = resp_mem[rise_cnt[10:3]][3'd7 - rise_cnt[2:0]];

   spi_master #(.HALF_PERIOD(HP), .SS_SETUP(SU), .SS_HOLD(SH), .SS_IDLE(SI)) u_dut (
      .clk(clk), .reset_n(reset_n), .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_last(tx_last),
      .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_byte_available(rx_byte_available), .busy(busy),
      .sclk(sclk), .mosi(mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback(loopback),
`endif
      .miso(miso), .ss(ss)
   );

   // Second instance at the tightest timing; its miso is wired to its own mosi.
   spi_master #(.HALF_PERIOD(2), .SS_SETUP(1), .SS_HOLD(1), .SS_IDLE(SI)) u_dut_fast (
      .clk(clk), .reset_n(reset_n), .tx_valid(f_tx_valid), .tx_byte(f_tx_byte), .tx_last(f_tx_last),
      .tx_ready(f_tx_ready), .rx_byte(f_rx_byte), .rx_byte_available(f_rx_avail), .busy(f_busy),
      .sclk(f_sclk), .mosi(f_mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .miso(f_mosi), .ss(f_ss)
   );

   typedef struct packed {
      logic       ss;
      logic       sclk;
      logic       mosi;
      logic       txr;
      logic       busy;
      logic       stb;
      logic [7:0] rx;
   } out_t;

   out_t m_cur;
   out_t m_q[$];
   int   m_ord = 0;
   int   st_ord = 0;

   int vectors = 0;
   int miscompares = 0;
   int nprint = 0;
   int cyc = 0;

   int   ss_low_cur, ss_low_last, ss_windows, rises, low_run, strobes, hi_run, hi_at_ready;
   logic prev_sclk, prev_txr;
   logic mosi_at_rise[$];
   int   low_runs[$];

   int   f_low_cur, f_low_last, f_rises, f_last_rise, f_pmin, f_pmax, f_strobes;
   logic f_prev_sclk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic out_t mk(input logic s, input logic c, input logic m, input logic r,
                               input logic b, input logic st, input logic [7:0] rx);
      out_t o;
      o.ss = s; o.sclk = c; o.mosi = m; o.txr = r; o.busy = b; o.stb = st; o.rx = rx;
      return o;
   endfunction

   task automatic model_reset();
      m_cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      m_q.delete();
      repeat (SI - 1) m_q.push_back(m_cur);
   endtask

   // Advance the model across one rising edge; an accepted byte appends its whole waveform.
   task automatic model_step();
      out_t       o;
      logic [7:0] r;
      logic       first;
      if (tx_valid && m_cur.txr) begin
         first = m_cur.ss;
         r     = loopback ? tx_byte : resp_mem[m_ord[7:0]];
         m_ord++;
         o = m_cur;
         o.ss = 1'b0; o.txr = 1'b0; o.busy = 1'b1; o.stb = 1'b0; o.sclk = 1'b0;
         o.mosi = tx_byte[7];
         if (first) repeat (SU) m_q.push_back(o);
         for (int i = 0; i < 8; i++) begin
            o.mosi = tx_byte[7-i];
            o.sclk = 1'b0;
            repeat (HP) m_q.push_back(o);
            o.sclk = 1'b1;
            repeat (HP) m_q.push_back(o);
         end
         o.sclk = 1'b0; o.stb = 1'b1; o.rx = r;
         if (tx_last) begin
            repeat (SH) begin
               m_q.push_back(o);
               o.stb = 1'b0;
            end
            o.ss = 1'b1;
            repeat (SI) m_q.push_back(o);
         end else begin
            o.txr = 1'b1;
            m_q.push_back(o);
         end
      end
      if (m_q.size() > 0) begin
         m_cur = m_q.pop_front();
      end else begin
         m_cur.stb  = 1'b0;
         m_cur.txr  = 1'b1;
         m_cur.sclk = 1'b0;
         m_cur.busy = ~m_cur.ss;
      end
   endtask

   task automatic tick();
      out_t d;
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
         model_reset();
         rise_cnt = 8 * m_ord;
      end else begin
         model_step();
      end

      d = mk(ss, sclk, mosi, tx_ready, busy, rx_byte_available, rx_byte);
      vectors++;
      if (d !== m_cur) begin
         miscompares++;
         if (nprint < 20) begin
            nprint++;
            $display("FAIL cycle_cmp t=%0t got ss=%b sclk=%b mosi=%b rdy=%b busy=%b stb=%b rx=%h required ss=%b sclk=%b mosi=%b rdy=%b busy=%b stb=%b rx=%h",
                     $time, d.ss, d.sclk, d.mosi, d.txr, d.busy, d.stb, d.rx,
                     m_cur.ss, m_cur.sclk, m_cur.mosi, m_cur.txr, m_cur.busy, m_cur.stb, m_cur.rx);
         end
      end

      if (!ss) ss_low_cur++;
      else if (ss_low_cur > 0) begin
         ss_low_last = ss_low_cur;
         ss_low_cur  = 0;
         ss_windows++;
      end
      if (sclk && !prev_sclk) begin
         rises++;
         rise_cnt++;
         mosi_at_rise.push_back(mosi);
         low_runs.push_back(low_run);
      end
      if (sclk) low_run = 0;
      else if (!ss) low_run++;
      if (rx_byte_available) strobes++;
      if (tx_ready && !prev_txr) hi_at_ready = hi_run;
      if (ss) hi_run++;
      else hi_run = 0;
      prev_sclk = sclk;
      prev_txr  = tx_ready;

      if (!f_ss) f_low_cur++;
      else if (f_low_cur > 0) begin
         f_low_last = f_low_cur;
         f_low_cur  = 0;
      end
      if (f_sclk && !f_prev_sclk) begin
         if (f_rises > 0) begin
            if (cyc - f_last_rise < f_pmin) f_pmin = cyc - f_last_rise;
            if (cyc - f_last_rise > f_pmax) f_pmax = cyc - f_last_rise;
         end
         f_rises++;
         f_last_rise = cyc;
      end
      if (f_rx_avail) f_strobes++;
      f_prev_sclk = f_sclk;
   endtask

   task automatic clear_mon();
      ss_low_cur = 0; ss_low_last = 0; ss_windows = 0; rises = 0; low_run = 0;
      strobes = 0; hi_at_ready = 0;
      mosi_at_rise.delete();
      low_runs.delete();
   endtask

   task automatic send(input logic [7:0] b, input logic last, input logic [7:0] r, input bit hold);
      int k;
      resp_mem[st_ord[7:0]] = r;
      st_ord++;
      tx_valid = 1'b1; tx_byte = b; tx_last = last;
      k = 0;
      while (!tx_ready && k < 3000) begin
         tick();
         k++;
      end
      if (k >= 3000) check("accept_timeout", 0, 1);
      tick();
      if (!hold) begin
         tx_valid = 1'b0;
         tx_byte  = 8'($urandom);
         tx_last  = 1'($urandom);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (!(tx_ready && ss) && k < 3000) begin
         tick();
         k++;
      end
      if (k >= 3000) check("idle_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         k;
      int         nb;
      bit         hold;
      logic       lst;
      logic [7:0] mb;
      bit         gap_ok;
      int         strobes_before;

      for (int i = 0; i < 256; i++) resp_mem[i] = 8'h00;
      reset_n = 1'b0; tx_valid = 1'b0; tx_byte = 8'h00; tx_last = 1'b0; loopback = 1'b0;
      f_tx_valid = 1'b0; f_tx_byte = 8'h00; f_tx_last = 1'b0;
      rise_cnt = 0; prev_sclk = 1'b0; prev_txr = 1'b0; hi_run = 0;
      f_low_cur = 0; f_low_last = 0; f_rises = 0; f_last_rise = 0; f_pmin = 999; f_pmax = 0;
      f_strobes = 0; f_prev_sclk = 1'b0;
      clear_mon();
      model_reset();

      repeat (3) tick();
      check("rst_ss", int'(ss), 1);
      check("rst_sclk", int'(sclk), 0);
      check("rst_mosi", int'(mosi), 0);
      check("rst_tx_ready", int'(tx_ready), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_rx_byte", int'(rx_byte), 0);
      check("rst_stb", int'(rx_byte_available), 0);
      reset_n = 1'b1;
      k = 0;
      while (!tx_ready && k < 50) begin
         tick();
         k++;
      end
      check("tx_ready_latency", k, 8);

      // Single byte 0xA5, slave returns 0x3C.
      clear_mon();
      send(8'hA5, 1'b1, 8'h3C, 1'b0);
      wait_idle();
      mb = 8'h00;
      for (int i = 0; i < 8; i++) mb = {mb[6:0], mosi_at_rise[i]};
      check("a5_rises", rises, 8);
      check("a5_mosi_bits", int'(mb), 8'hA5);
      check("a5_ss_low", ss_low_last, 72);
      check("a5_rx", int'(rx_byte), 8'h3C);
      check("a5_strobes", strobes, 1);
      check("a5_idle_gap", int'(hi_at_ready >= 8), 1);

      // Three bytes back-to-back, slave echoes each byte.
      clear_mon();
      send(8'h01, 1'b0, 8'h01, 1'b1);
      send(8'h80, 1'b0, 8'h80, 1'b1);
      send(8'hFF, 1'b1, 8'hFF, 1'b0);
      wait_idle();
      check("b2b_windows", ss_windows, 1);
      check("b2b_rises", rises, 24);
      check("b2b_gap1", low_runs[8], HP + 1);
      check("b2b_gap2", low_runs[16], HP + 1);
      check("b2b_strobes", strobes, 3);
      check("b2b_rx", int'(rx_byte), 8'hFF);

      // Two bytes with a 20-cycle stall in NEXT.
      clear_mon();
      send(8'h33, 1'b0, 8'h9E, 1'b0);
      k = 0;
      while (!tx_ready && k < 3000) begin
         tick();
         k++;
      end
      gap_ok = 1'b1;
      repeat (20) begin
         tick();
         if (ss || sclk || !tx_ready) gap_ok = 1'b0;
      end
      check("stall_hold", int'(gap_ok), 1);
      send(8'hC6, 1'b1, 8'h41, 1'b0);
      wait_idle();
      check("stall_windows", ss_windows, 1);
      check("stall_rises", rises, 16);
      check("stall_low_run", low_runs[8], 1 + 20 + HP);
      check("stall_rx", int'(rx_byte), 8'h41);

      // Reset during bit 4 of 0xC3, then a clean 0x5A.
      clear_mon();
      send(8'hC3, 1'b1, 8'h77, 1'b0);
      k = 0;
      while (rises < 4 && k < 200) begin
         tick();
         k++;
      end
      strobes_before = strobes;
      #2 reset_n = 1'b0;
      #1;
      check("arst_ss", int'(ss), 1);
      check("arst_sclk", int'(sclk), 0);
      check("arst_stb", int'(rx_byte_available), 0);
      tick();
      tick();
      reset_n = 1'b1;
      check("arst_no_strobe", strobes, strobes_before);
      clear_mon();
      send(8'h5A, 1'b1, 8'hE7, 1'b0);
      wait_idle();
      check("post_rst_rx", int'(rx_byte), 8'hE7);
      check("post_rst_ss_low", ss_low_last, 72);
      check("post_rst_strobes", strobes, 1);

      // Fast instance: HALF_PERIOD=2, SS_SETUP=1, SS_HOLD=1, byte 0x96.
      f_tx_valid = 1'b1; f_tx_byte = 8'h96; f_tx_last = 1'b1;
      k = 0;
      while (!f_tx_ready && k < 100) begin
         tick();
         k++;
      end
      tick();
      f_tx_valid = 1'b0;
      k = 0;
      while (f_low_last == 0 && k < 200) begin
         tick();
         k++;
      end
      check("fast_ss_low", f_low_last, 34);
      check("fast_rises", f_rises, 8);
      check("fast_period_min", f_pmin, 4);
      check("fast_period_max", f_pmax, 4);
      check("fast_rx", int'(f_rx_byte), 8'h96);
      check("fast_strobes", f_strobes, 1);
      check("fast_busy", int'(f_busy), 1);

`ifdef SPI_MASTER_LOOPBACK_EN
      clear_mon();
      loopback = 1'b1;
      send(8'h6B, 1'b1, 8'h00, 1'b0);
      wait_idle();
      check("loopback_rx", int'(rx_byte), 8'h6B);
      loopback = 1'b0;
`endif

      // Random transactions of 1..4 bytes with random stalls and idle gaps.
      for (int t = 0; t < 25; t++) begin
         nb = $urandom_range(1, 4);
         for (int j = 0; j < nb; j++) begin
            lst  = (j == nb - 1);
            hold = !lst && ($urandom_range(0, 1) == 1);
            send(8'($urandom), lst, 8'($urandom), hold);
            if (!hold && !lst) repeat ($urandom_range(0, 6)) tick();
         end
         repeat ($urandom_range(0, 12)) tick();
      end
      wait_idle();
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
